// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the VGA timing generator and the pixel renderer.
// clk25 comes from the /4 divider and is treated as data, not as a clock.
interface vga_timing_gen_if;
  logic       clk25;
  logic       pixel_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;

  modport master (
    input  clk25,
    output pixel_tick, hsync, vsync, video_on, x, y, frame_start
  );

  modport slave (
    output clk25,
    input  pixel_tick, hsync, vsync, video_on, x, y, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator on the system clock: edge-detects the divider's clk25
// into a one-clk pixel tick and sequences registered sync/coordinate outputs.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       clk25_q;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, vsync_q, video_on_q, frame_start_q;
  logic       hsync_d, vsync_d, video_on_d, frame_start_d;
  logic [9:0] x_q, y_q;
  logic       pixel_tick;

  assign pixel_tick = vga.clk25 & ~clk25_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Output decode uses the pre-increment counters, so outputs trail the counters by one pixel.
  assign hsync_d       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
  assign vsync_d       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  assign video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk25_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      clk25_q       <= vga.clk25;
      frame_start_q <= 1'b0;
      if (pixel_tick) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        video_on_q    <= video_on_d;
        x_q           <= h_cnt_q;
        y_q           <= v_cnt_q;
        frame_start_q <= frame_start_d;
      end
    end
  end

  assign vga.pixel_tick  = pixel_tick;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a shrunken-frame instance
// share one clk25 stream; a pixel-index model feeds a per-instance expected-output queue.
module tb_vga_timing_gen;

  // Instance 0 uses the default timing, instance 1 a tiny 15x8 frame so wraps are reachable.
  localparam int HV_A [2] = '{640, 8};
  localparam int HF_A [2] = '{16, 2};
  localparam int HS_A [2] = '{96, 3};
  localparam int HB_A [2] = '{48, 2};
  localparam int VV_A [2] = '{480, 4};
  localparam int VF_A [2] = '{10, 1};
  localparam int VS_A [2] = '{2, 2};
  localparam int VB_A [2] = '{33, 1};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       fs;
  } out_t;

  typedef struct {
    int tick;
    int x;
    int y;
    int hs;
    int vs;
    int vo;
    int fs;
  } vec_t;

  logic clk;
  logic reset;
  logic clk25;
  int   mode;     // 0: clean /4, 1: held high, 2: jittered 2..6 clk period

  int   n_cmp;
  int   n_fail;
  int   tick_cnt;
  logic m_c25q;
  logic m_tick;
  int   pix [2];
  out_t exp_cur [2];
  out_t sbq [2][$];

  vga_timing_gen_if ifd ();
  vga_timing_gen_if ifs ();

  assign ifd.clk25 = clk25;
  assign ifs.clk25 = clk25;

  vga_timing_gen dut_def (
    .clk   (clk),
    .reset (reset),
    .vga   (ifd)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) dut_small (
    .clk   (clk),
    .reset (reset),
    .vga   (ifs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int left;
    clk25 = 1'b0;
    left  = 2;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        clk25 = 1'b1;
      end else if (left <= 1) begin
        clk25 = ~clk25;
        left  = (mode == 2) ? int'($urandom_range(1, 3)) : 2;
      end else begin
        left = left - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int htot(input int d);
    return HV_A[d] + HF_A[d] + HS_A[d] + HB_A[d];
  endfunction

  function automatic int vtot(input int d);
    return VV_A[d] + VF_A[d] + VS_A[d] + VB_A[d];
  endfunction

  function automatic out_t rst_out();
    out_t o;
    o.x = '0; o.y = '0; o.hs = 1'b1; o.vs = 1'b1; o.vo = 1'b0; o.fs = 1'b0;
    return o;
  endfunction

  // Expected outputs for linear pixel index p within the frame.
  function automatic out_t model_out(input int d, input int p);
    out_t o;
    int xx, yy;
    xx   = p % htot(d);
    yy   = p / htot(d);
    o.x  = 10'(xx);
    o.y  = 10'(yy);
    o.hs = !(xx >= HV_A[d] + HF_A[d] && xx < HV_A[d] + HF_A[d] + HS_A[d]);
    o.vs = !(yy >= VV_A[d] + VF_A[d] && yy < VV_A[d] + VF_A[d] + VS_A[d]);
    o.vo = (xx < HV_A[d]) && (yy < VV_A[d]);
    o.fs = (p == 0);
    return o;
  endfunction

  function automatic out_t get_out(input int d);
    out_t o;
    if (d == 0) begin
      o.x = ifd.x; o.y = ifd.y; o.hs = ifd.hsync; o.vs = ifd.vsync;
      o.vo = ifd.video_on; o.fs = ifd.frame_start;
    end else begin
      o.x = ifs.x; o.y = ifs.y; o.hs = ifs.hsync; o.vs = ifs.vsync;
      o.vo = ifs.video_on; o.fs = ifs.frame_start;
    end
    return o;
  endfunction

  function automatic logic get_tick(input int d);
    return (d == 0) ? ifd.pixel_tick : ifs.pixel_tick;
  endfunction

  task automatic cmp_out(input string tag, input int d, input out_t e);
    out_t a;
    a = get_out(d);
    chk($sformatf("%s.d%0d.x", tag, d), int'(a.x), int'(e.x));
    chk($sformatf("%s.d%0d.y", tag, d), int'(a.y), int'(e.y));
    chk($sformatf("%s.d%0d.hsync", tag, d), int'(a.hs), int'(e.hs));
    chk($sformatf("%s.d%0d.vsync", tag, d), int'(a.vs), int'(e.vs));
    chk($sformatf("%s.d%0d.video_on", tag, d), int'(a.vo), int'(e.vo));
    chk($sformatf("%s.d%0d.frame_start", tag, d), int'(a.fs), int'(e.fs));
  endtask

  // Scoreboard: push expected outputs on each model tick, pop them one clk later.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        sbq[d].delete();
        exp_cur[d] = rst_out();
        pix[d]     = 0;
        cmp_out("sb_rst", d, exp_cur[d]);
        chk($sformatf("sb_rst.d%0d.pixel_tick", d), int'(get_tick(d)), int'(clk25));
      end
      m_c25q   = 1'b0;
      tick_cnt = 0;
    end else begin
      m_tick = clk25 & ~m_c25q;
      m_c25q = clk25;
      for (int d = 0; d < 2; d++) begin
        if (sbq[d].size() > 0) exp_cur[d] = sbq[d].pop_front();
        else exp_cur[d].fs = 1'b0;
        cmp_out("sb", d, exp_cur[d]);
        chk($sformatf("sb.d%0d.pixel_tick", d), int'(get_tick(d)), int'(m_tick));
        if (m_tick) begin
          sbq[d].push_back(model_out(d, pix[d]));
          pix[d] = (pix[d] + 1) % (htot(d) * vtot(d));
        end
      end
      if (m_tick) tick_cnt++;
    end
  end

  task automatic wait_ticks(input int k, input int budget);
    int g;
    g = 0;
    while (tick_cnt < k && g < budget) begin
      @(posedge clk);
      g++;
    end
    chk($sformatf("wait_tick_%0d_in_budget", k), int'(tick_cnt >= k), 1);
    #2;
  endtask

  task automatic wait_fs_small(output int t);
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #2;
      g++;
    end while (!ifs.frame_start && g < 2000);
    chk("frame_start_seen", int'(ifs.frame_start), 1);
    t = tick_cnt;
  endtask

  initial begin
    vec_t tbl [10];
    out_t e;
    int   n, t1, t2, start, g;

    n_cmp  = 0;
    n_fail = 0;
    mode   = 0;
    reset  = 1'b0;

    tbl[0] = '{1,   0,   0, 1, 1, 1, 1};
    tbl[1] = '{2,   1,   0, 1, 1, 1, 0};
    tbl[2] = '{640, 639, 0, 1, 1, 1, 0};
    tbl[3] = '{641, 640, 0, 1, 1, 0, 0};
    tbl[4] = '{656, 655, 0, 1, 1, 0, 0};
    tbl[5] = '{657, 656, 0, 0, 1, 0, 0};
    tbl[6] = '{752, 751, 0, 0, 1, 0, 0};
    tbl[7] = '{753, 752, 0, 1, 1, 0, 0};
    tbl[8] = '{800, 799, 0, 1, 1, 0, 0};
    tbl[9] = '{801, 0,   1, 1, 1, 1, 0};

    // Reset held with clk25 toggling.
    repeat (20) @(posedge clk);
    #2;
    cmp_out("reset_hold", 0, rst_out());
    cmp_out("reset_hold", 1, rst_out());

    @(posedge clk);
    #1;
    reset = 1'b1;

    // First line of the default-timing instance.
    foreach (tbl[i]) begin
      wait_ticks(tbl[i].tick, 4000);
      chk($sformatf("line.t%0d.x", tbl[i].tick), int'(ifd.x), tbl[i].x);
      chk($sformatf("line.t%0d.y", tbl[i].tick), int'(ifd.y), tbl[i].y);
      chk($sformatf("line.t%0d.hsync", tbl[i].tick), int'(ifd.hsync), tbl[i].hs);
      chk($sformatf("line.t%0d.vsync", tbl[i].tick), int'(ifd.vsync), tbl[i].vs);
      chk($sformatf("line.t%0d.video_on", tbl[i].tick), int'(ifd.video_on), tbl[i].vo);
      chk($sformatf("line.t%0d.frame_start", tbl[i].tick), int'(ifd.frame_start), tbl[i].fs);
    end

    // Clean /4 divider: one tick per 4 clk.
    n = 0;
    repeat (400) begin
      @(negedge clk);
      if (ifd.pixel_tick) n++;
    end
    chk("ticks_per_400clk", n, 100);

    // clk25 stuck high: no ticks, outputs frozen (scoreboard covers the hold).
    mode = 1;
    repeat (3) @(posedge clk);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (ifd.pixel_tick || ifs.pixel_tick) n++;
    end
    chk("ticks_while_static", n, 0);
    mode = 0;

    // Full-frame period on the small instance.
    wait_fs_small(t1);
    wait_fs_small(t2);
    chk("frame_period_ticks", t2 - t1, htot(1) * vtot(1));

    // Mid-frame asynchronous reset.
    g = 0;
    do begin
      @(posedge clk);
      #2;
      g++;
    end while (!(ifs.x == 10'd5 && ifs.y == 10'd2) && g < 2000);
    chk("midframe_reached", int'(ifs.x == 10'd5 && ifs.y == 10'd2), 1);
    #1;
    reset = 1'b0;
    #1;
    cmp_out("async_rst", 0, rst_out());
    cmp_out("async_rst", 1, rst_out());
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ticks(1, 100);
    e = model_out(0, 0);
    cmp_out("after_rst_t1", 0, e);
    e = model_out(1, 0);
    cmp_out("after_rst_t1", 1, e);
    chk("after_rst_t1.vo_explicit", int'(ifs.video_on), 1);
    wait_ticks(2, 100);
    chk("after_rst_t2.x", int'(ifs.x), 1);
    chk("after_rst_t2.frame_start", int'(ifs.frame_start), 0);

    // Jittered clk25 period; the scoreboard checks contiguity of every tick.
    mode  = 2;
    start = tick_cnt;
    wait_ticks(start + 2000, 20000);
    mode = 0;
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
